serial_parity_checker: RTL and testbench

//  Serial front-end stage that feeds the XOR parity logic in the lab datapath.

---
 rtl/serial_parity_checker.sv | 133 +++++++++++++
 tb/tb_serial_parity_checker.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_parity_checker.sv
// Serial parity checker.
// Takes a frame over a valid/ready bit stream: DATA_BITS data bits, LSB first,
// then one parity bit. It reassembles the word, XOR-accumulates the whole frame,
// and presents the word and a parity-error flag over a valid/ready handshake.
module serial_parity_checker #(
    parameter int DATA_BITS  = 8,
    parameter bit ODD_PARITY = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_bit,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_BITS-1:0] out_data,
    output logic                 out_parity_err,
    output logic                 busy
);

    // The counter has to reach DATA_BITS itself, so it is sized for DATA_BITS+1 values.
    localparam int              CW       = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0]   LAST_IDX = CW'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PAR,
        DONE
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [CW-1:0]          count;
    logic                   acc;
    logic [DATA_BITS-1:0]   shift;
    logic                   bit_xfer;
    logic                   frame_xfer;

    assign bit_xfer   = in_valid && in_ready;
    assign frame_xfer = out_valid && out_ready;

    // Moore output decode; in_ready is gated by reset so every output is 0 while rst_n=0.
    always_comb begin
        // NOTE: every output gets a default before the case so no path infers a latch.
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                in_ready = rst_n;
                busy     = 1'b0;
            end
            DATA:    in_ready  = rst_n;
            PAR:     in_ready  = rst_n;
            DONE:    out_valid = 1'b1;
            default: busy      = 1'b0;
        endcase
    end

    // Next-state logic for the frame sequencer.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bit_xfer) state_nxt = (DATA_BITS == 1) ? PAR : DATA;
            DATA: if (bit_xfer && (count == LAST_IDX)) state_nxt = PAR;
            PAR:  if (bit_xfer) state_nxt = DONE;
            DONE: if (frame_xfer) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register
            // samples pre-edge values regardless of block evaluation order.
            state <= state_nxt;
        end
    end

    // Datapath: shift register, XOR accumulator, bit counter and the output holding registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count          <= '0;
            acc            <= 1'b0;
            // NOTE: the shift register is a plain register bank, not a memory, so it
            // is cleared by reset along with the rest of the frame state.
            shift          <= '0;
            out_data       <= '0;
            out_parity_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bit_xfer) begin
                        shift[0] <= in_bit;
                        acc      <= in_bit;
                        count    <= CW'(1);
                    end
                end
                DATA: begin
                    if (bit_xfer) begin
                        for (int i = 0; i < DATA_BITS; i++) begin
                            if (count == CW'(i)) shift[i] <= in_bit;
                        end
                        acc   <= acc ^ in_bit;
                        count <= count + CW'(1);
                    end
                end
                PAR: begin
                    if (bit_xfer) begin
                        out_data       <= shift;
                        out_parity_err <= acc ^ in_bit ^ ODD_PARITY;
                    end
                end
                DONE: begin
                    // out_data/out_parity_err deliberately keep their values after the handshake.
                    if (frame_xfer) begin
                        acc   <= 1'b0;
                        count <= '0;
                    end
                end
                default: begin
                    acc   <= 1'b0;
                    count <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_parity_checker.sv
// Bench for serial_parity_checker: an 8-bit even-parity instance and a 1-bit
// odd-parity instance, compared every cycle against a frame-level model.
module tb_serial_parity_checker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] iv   = '0;
    logic [1:0] ib   = '0;
    logic [1:0] ordy = '0;
    logic [1:0] irdy;
    logic [1:0] ov;
    logic [1:0] perr;
    logic [1:0] bsy;
    logic [7:0] od8;
    logic       od1;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    serial_parity_checker #(.DATA_BITS(8), .ODD_PARITY(1'b0)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv[0]), .in_ready(irdy[0]), .in_bit(ib[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]),
        .out_data(od8), .out_parity_err(perr[0]), .busy(bsy[0])
    );

    serial_parity_checker #(.DATA_BITS(1), .ODD_PARITY(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv[1]), .in_ready(irdy[1]), .in_bit(ib[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]),
        .out_data(od1), .out_parity_err(perr[1]), .busy(bsy[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- frame-level reference model ----------------
    localparam int NBITS [2] = '{8, 1};
    localparam bit ODD   [2] = '{1'b0, 1'b1};

    logic [0:0] bitq0 [$];
    logic [0:0] bitq1 [$];
    bit         pres [2] = '{0, 0};
    logic [7:0] ed   [2] = '{8'h00, 8'h00};
    logic       ee   [2] = '{1'b0, 1'b0};

    function automatic int qsize(input int k);
        return (k == 0) ? bitq0.size() : bitq1.size();
    endfunction

    // Close a frame: data is the first NBITS bits, error when the count of ones
    // in the whole frame has the wrong parity.
    task automatic close_frame(input int k, input logic pbit);
        logic [0:0] q [$];
        int ones;
        q = (k == 0) ? bitq0 : bitq1;
        ones = int'(pbit);
        ed[k] = 8'h00;
        for (int i = 0; i < q.size(); i++) begin
            ed[k] = ed[k] + (8'(q[i]) << i);
            ones  = ones + int'(q[i]);
        end
        ee[k] = ((ones % 2) == 1) != ODD[k];
        pres[k] = 1'b1;
        if (k == 0) bitq0.delete(); else bitq1.delete();
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bitq0.delete();
            bitq1.delete();
            for (int k = 0; k < 2; k++) begin
                pres[k] = 1'b0;
                ed[k]   = 8'h00;
                ee[k]   = 1'b0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (pres[k]) begin
                    if (ordy[k]) pres[k] = 1'b0;
                end else if (iv[k]) begin
                    if (qsize(k) < NBITS[k]) begin
                        if (k == 0) bitq0.push_back(ib[k]); else bitq1.push_back(ib[k]);
                    end else begin
                        close_frame(k, ib[k]);
                    end
                end
            end
        end
    end

    // Compare every output of both instances on every falling edge.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            check($sformatf("in_ready[%0d]", k), 32'(irdy[k]), 32'(rst_n && !pres[k]));
            check($sformatf("out_valid[%0d]", k), 32'(ov[k]), 32'(pres[k]));
            check($sformatf("busy[%0d]", k), 32'(bsy[k]), 32'(pres[k] || (qsize(k) != 0)));
            check($sformatf("out_data[%0d]", k), (k == 0) ? 32'(od8) : 32'(od1), 32'(ed[k]));
            check($sformatf("out_parity_err[%0d]", k), 32'(perr[k]), 32'(ee[k]));
        end
    end

    // Counts out_valid rising edges on the 8-bit instance.
    int  ov_rises = 0;
    bit  ov0_prev = 1'b0;
    always @(negedge clk) begin
        if (ov[0] && !ov0_prev) ov_rises++;
        ov0_prev = ov[0];
    end

    // ---------------- stimulus ----------------
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bit(input int k, input logic b);
        int budget = 50;
        iv[k] = 1'b1;
        ib[k] = b;
        while (!irdy[k] && budget > 0) begin
            @(posedge clk);
            #1;
            budget--;
        end
        if (budget == 0) check("accept_wait", 32'(irdy[k]), 32'd1);
        @(posedge clk);
        #1;
        iv[k] = 1'b0;
    endtask

    task automatic send_frame(input int k, input logic [7:0] data, input int n,
                              input logic par, input bit gaps);
        for (int i = 0; i < n; i++) begin
            send_bit(k, data[i]);
            if (gaps) idle($urandom_range(0, 2));
        end
        send_bit(k, par);
        check("latency_out_valid", 32'(ov[k]), 32'd1);
    endtask

    task automatic take_frame(input int k, input int hold);
        ordy[k] = 1'b0;
        idle(hold);
        ordy[k] = 1'b1;
        @(posedge clk);
        #1;
        ordy[k] = 1'b0;
        check("handshake_release", 32'(ov[k]), 32'd0);
    endtask

    initial begin
        // 1. Reset with in_valid high: everything 0.
        iv = 2'b11;
        ib = 2'b11;
        idle(3);
        check("reset_in_ready", 32'(irdy), 32'd0);
        check("reset_busy", 32'(bsy), 32'd0);
        check("reset_out_valid", 32'(ov), 32'd0);
        rst_n = 1'b1;
        iv = 2'b00;
        idle(1);
        check("post_reset_in_ready", 32'(irdy), 32'd3);
        check("post_reset_busy", 32'(bsy), 32'd0);

        // 2. Good frame A5, even parity 0.
        send_frame(0, 8'hA5, 8, 1'b0, 1'b0);
        check("good_data", 32'(od8), 32'hA5);
        check("good_err", 32'(perr[0]), 32'd0);
        take_frame(0, 0);

        // 3. Same data, wrong parity.
        send_frame(0, 8'hA5, 8, 1'b1, 1'b0);
        check("bad_data", 32'(od8), 32'hA5);
        check("bad_err", 32'(perr[0]), 32'd1);
        take_frame(0, 0);

        // 4. Backpressure with ignored extra bits, then a second frame.
        send_frame(0, 8'h3C, 8, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            iv[0] = 1'b1;
            ib[0] = i[0];
            @(posedge clk);
            #1;
            check("bp_out_valid", 32'(ov[0]), 32'd1);
            check("bp_data", 32'(od8), 32'h3C);
            check("bp_in_ready", 32'(irdy[0]), 32'd0);
        end
        iv[0] = 1'b0;
        take_frame(0, 0);
        check("bp_idle_busy", 32'(bsy[0]), 32'd0);
        send_frame(0, 8'h01, 8, 1'b1, 1'b0);
        check("second_data", 32'(od8), 32'h01);
        check("second_err", 32'(perr[0]), 32'd0);
        take_frame(0, 1);

        // 5. Partial frame, reset mid-frame, then a gappy FF frame.
        for (int i = 0; i < 4; i++) send_bit(0, 1'b1);
        ov_rises = 0;
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(1);
        send_frame(0, 8'hFF, 8, 1'b0, 1'b1);
        take_frame(0, 2);
        idle(3);
        check("midreset_pulses", 32'(ov_rises), 32'd1);
        check("midreset_data", 32'(od8), 32'hFF);
        check("midreset_err", 32'(perr[0]), 32'd0);

        // 6. DATA_BITS=1, odd parity.
        send_frame(1, 8'h00, 1, 1'b1, 1'b0);
        check("odd_ok_err", 32'(perr[1]), 32'd0);
        check("odd_ok_data", 32'(od1), 32'd0);
        take_frame(1, 0);
        send_frame(1, 8'h01, 1, 1'b1, 1'b0);
        check("odd_bad_err", 32'(perr[1]), 32'd1);
        check("odd_bad_data", 32'(od1), 32'd1);
        take_frame(1, 0);

        // Randomized frames, gaps, backpressure and ignored bits on both instances.
        for (int it = 0; it < 40; it++) begin
            int k;
            int hold;
            k = it % 2;
            send_frame(k, 8'($urandom), NBITS[k], 1'($urandom), 1'b1);
            hold = $urandom_range(0, 3);
            for (int h = 0; h < hold; h++) begin
                iv[k] = 1'($urandom);
                ib[k] = 1'($urandom);
                @(posedge clk);
                #1;
            end
            iv[k] = 1'b0;
            take_frame(k, $urandom_range(0, 1));
            idle($urandom_range(0, 2));
        end

        idle(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1);
    end

endmodule
